memory_access_stage: RTL and testbench

//  MIPS MEM stage, directly downstream of execute_top.
//  - Latches execute outputs into the EX/MEM register: ALU result, rb data, write register, control.
//  - Performs byte/half/word load/store against an internal data RAM.
//  - Latches the results into the MEM/WB register that feeds write-back and the forwarding unit.

---
 rtl/memory_access_stage_pkg.sv | 19 +
 rtl/memory_access_stage_data_memory.sv | 43 ++++
 rtl/memory_access_stage.sv | 192 +++++++++++++++++++
 tb/tb_memory_access_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_stage_pkg.sv
// Shared encodings and helpers for the MEM stage: access-width codes and the alignment rule.
package memory_access_stage_pkg;

  localparam logic [1:0] MEM_WIDTH_BYTE = 2'b00;
  localparam logic [1:0] MEM_WIDTH_HALF = 2'b01;
  localparam logic [1:0] MEM_WIDTH_WORD = 2'b10;

  // Width code 2'b11 behaves as a word access.
  function automatic logic addr_misaligned(input logic [1:0] width, input logic [1:0] lane);
    logic mis;
    case (width)
      MEM_WIDTH_BYTE: mis = 1'b0;
      MEM_WIDTH_HALF: mis = lane[0];
      default:        mis = |lane;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/memory_access_stage_data_memory.sv
// Word-organised data RAM: byte-enable synchronous write, combinational read, registered debug read.
module memory_access_stage_data_memory #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_ADDR = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic               we_i,
  input  logic [3:0]         be_i,
  input  logic [NB_ADDR-1:0] addr_i,
  input  logic [NB_DATA-1:0] wdata_i,
  output logic [NB_DATA-1:0] rdata_o,
  input  logic [NB_ADDR-1:0] debug_addr_i,
  output logic [NB_DATA-1:0] debug_data_o
);

  logic [NB_DATA-1:0] mem [2**NB_ADDR];
  logic [NB_DATA-1:0] debug_q, debug_d;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem[addr_i];

  always_comb begin
    debug_d = debug_q;
    if (enable_i) debug_d = mem[debug_addr_i];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) debug_q <= '0;
    else         debug_q <= debug_d;
  end

  assign debug_data_o = debug_q;

endmodule

// File: rtl/memory_access_stage.sv
// MIPS MEM stage: EX/MEM register, byte-lane load/store against the data RAM, MEM/WB register.
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_REG  = 5,
  parameter int unsigned NB_ADDR = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic               flush_i,
  input  logic [NB_DATA-1:0] alu_result_i,
  input  logic [NB_DATA-1:0] data_rb_i,
  input  logic [NB_REG-1:0]  write_reg_i,
  input  logic               mem_read_i,
  input  logic               mem_write_i,
  input  logic               reg_write_i,
  input  logic               mem_to_reg_i,
  input  logic [1:0]         mem_width_i,
  input  logic               mem_unsigned_i,
  input  logic               halt_i,
  input  logic [NB_ADDR-1:0] debug_addr_i,
  output logic [NB_DATA-1:0] exmem_alu_o,
  output logic [NB_REG-1:0]  exmem_reg_o,
  output logic               exmem_reg_write_o,
  output logic [NB_DATA-1:0] wb_data_o,
  output logic [NB_REG-1:0]  wb_reg_o,
  output logic               wb_reg_write_o,
  output logic               misaligned_o,
  output logic               halt_o,
  output logic [NB_DATA-1:0] debug_data_o
);

  logic [NB_DATA-1:0] exmem_alu_q, exmem_alu_d, exmem_rb_q, exmem_rb_d;
  logic [NB_REG-1:0]  exmem_reg_q, exmem_reg_d;
  logic               exmem_mem_read_q, exmem_mem_read_d, exmem_mem_write_q, exmem_mem_write_d;
  logic               exmem_reg_write_q, exmem_reg_write_d, exmem_mem_to_reg_q, exmem_mem_to_reg_d;
  logic [1:0]         exmem_width_q, exmem_width_d;
  logic               exmem_unsigned_q, exmem_unsigned_d, exmem_halt_q, exmem_halt_d;

  logic [NB_DATA-1:0] wb_data_q, wb_data_d;
  logic [NB_REG-1:0]  wb_reg_q, wb_reg_d;
  logic               wb_reg_write_q, wb_reg_write_d, wb_mis_q, wb_mis_d, wb_halt_q, wb_halt_d;

  logic [1:0]         lane;
  logic               misaligned, ram_we;
  logic [3:0]         store_be;
  logic [NB_DATA-1:0] store_wdata, ram_rdata, shifted, load_data;

  always_comb begin
    exmem_alu_d        = exmem_alu_q;
    exmem_rb_d         = exmem_rb_q;
    exmem_reg_d        = exmem_reg_q;
    exmem_mem_read_d   = exmem_mem_read_q;
    exmem_mem_write_d  = exmem_mem_write_q;
    exmem_reg_write_d  = exmem_reg_write_q;
    exmem_mem_to_reg_d = exmem_mem_to_reg_q;
    exmem_width_d      = exmem_width_q;
    exmem_unsigned_d   = exmem_unsigned_q;
    exmem_halt_d       = exmem_halt_q;
    if (enable_i) begin
      exmem_alu_d        = alu_result_i;
      exmem_rb_d         = data_rb_i;
      exmem_reg_d        = write_reg_i;
      exmem_width_d      = mem_width_i;
      exmem_unsigned_d   = mem_unsigned_i;
      // A flush turns the slot into a bubble by clearing every control bit.
      exmem_mem_read_d   = mem_read_i   & ~flush_i;
      exmem_mem_write_d  = mem_write_i  & ~flush_i;
      exmem_reg_write_d  = reg_write_i  & ~flush_i;
      exmem_mem_to_reg_d = mem_to_reg_i & ~flush_i;
      exmem_halt_d       = halt_i       & ~flush_i;
    end
  end

  assign lane       = exmem_alu_q[1:0];
  assign misaligned = (exmem_mem_read_q | exmem_mem_write_q) &
                      addr_misaligned(exmem_width_q, lane);

  always_comb begin
    case (exmem_width_q)
      MEM_WIDTH_BYTE: begin
        store_be    = 4'b0001 << lane;
        store_wdata = {(NB_DATA/8){exmem_rb_q[7:0]}};
      end
      MEM_WIDTH_HALF: begin
        store_be    = 4'b0011 << lane;
        store_wdata = {(NB_DATA/16){exmem_rb_q[15:0]}};
      end
      default: begin
        store_be    = 4'b1111;
        store_wdata = exmem_rb_q;
      end
    endcase
  end

  // Reset wins over a store sitting in EX/MEM.
  assign ram_we = exmem_mem_write_q & enable_i & ~reset_i & ~misaligned;

  memory_access_stage_data_memory #(
    .NB_DATA(NB_DATA),
    .NB_ADDR(NB_ADDR)
  ) u_data_memory (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .enable_i    (enable_i),
    .we_i        (ram_we),
    .be_i        (store_be),
    .addr_i      (exmem_alu_q[NB_ADDR+1:2]),
    .wdata_i     (store_wdata),
    .rdata_o     (ram_rdata),
    .debug_addr_i(debug_addr_i),
    .debug_data_o(debug_data_o)
  );

  assign shifted = ram_rdata >> {lane, 3'b000};

  always_comb begin
    case (exmem_width_q)
      MEM_WIDTH_BYTE: load_data = exmem_unsigned_q ?
                                  {{(NB_DATA-8){1'b0}}, shifted[7:0]} :
                                  {{(NB_DATA-8){shifted[7]}}, shifted[7:0]};
      MEM_WIDTH_HALF: load_data = exmem_unsigned_q ?
                                  {{(NB_DATA-16){1'b0}}, shifted[15:0]} :
                                  {{(NB_DATA-16){shifted[15]}}, shifted[15:0]};
      default:        load_data = ram_rdata;
    endcase
    if (misaligned) load_data = '0;
  end

  always_comb begin
    wb_data_d      = wb_data_q;
    wb_reg_d       = wb_reg_q;
    wb_reg_write_d = wb_reg_write_q;
    wb_mis_d       = wb_mis_q;
    wb_halt_d      = wb_halt_q;
    if (enable_i) begin
      wb_data_d      = exmem_mem_to_reg_q ? load_data : exmem_alu_q;
      wb_reg_d       = exmem_reg_q;
      wb_reg_write_d = exmem_reg_write_q;
      wb_mis_d       = misaligned;
      wb_halt_d      = exmem_halt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      exmem_alu_q        <= '0;
      exmem_rb_q         <= '0;
      exmem_reg_q        <= '0;
      exmem_mem_read_q   <= 1'b0;
      exmem_mem_write_q  <= 1'b0;
      exmem_reg_write_q  <= 1'b0;
      exmem_mem_to_reg_q <= 1'b0;
      exmem_width_q      <= 2'b00;
      exmem_unsigned_q   <= 1'b0;
      exmem_halt_q       <= 1'b0;
      wb_data_q          <= '0;
      wb_reg_q           <= '0;
      wb_reg_write_q     <= 1'b0;
      wb_mis_q           <= 1'b0;
      wb_halt_q          <= 1'b0;
    end else begin
      exmem_alu_q        <= exmem_alu_d;
      exmem_rb_q         <= exmem_rb_d;
      exmem_reg_q        <= exmem_reg_d;
      exmem_mem_read_q   <= exmem_mem_read_d;
      exmem_mem_write_q  <= exmem_mem_write_d;
      exmem_reg_write_q  <= exmem_reg_write_d;
      exmem_mem_to_reg_q <= exmem_mem_to_reg_d;
      exmem_width_q      <= exmem_width_d;
      exmem_unsigned_q   <= exmem_unsigned_d;
      exmem_halt_q       <= exmem_halt_d;
      wb_data_q          <= wb_data_d;
      wb_reg_q           <= wb_reg_d;
      wb_reg_write_q     <= wb_reg_write_d;
      wb_mis_q           <= wb_mis_d;
      wb_halt_q          <= wb_halt_d;
    end
  end

  assign exmem_alu_o       = exmem_alu_q;
  assign exmem_reg_o       = exmem_reg_q;
  assign exmem_reg_write_o = exmem_reg_write_q;
  assign wb_data_o         = wb_data_q;
  assign wb_reg_o          = wb_reg_q;
  assign wb_reg_write_o    = wb_reg_write_q;
  assign misaligned_o      = wb_mis_q;
  assign halt_o            = wb_halt_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboard bench for memory_access_stage: byte-array reference model, random and directed traffic.
module tb_memory_access_stage;

  logic        clk_i = 1'b0;
  logic        reset_i, enable_i, flush_i;
  logic [31:0] alu_result_i, data_rb_i;
  logic [4:0]  write_reg_i;
  logic        mem_read_i, mem_write_i, reg_write_i, mem_to_reg_i, mem_unsigned_i, halt_i;
  logic [1:0]  mem_width_i;
  logic [7:0]  debug_addr_i;
  logic [31:0] exmem_alu_o, wb_data_o, debug_data_o;
  logic [4:0]  exmem_reg_o, wb_reg_o;
  logic        exmem_reg_write_o, wb_reg_write_o, misaligned_o, halt_o;

  memory_access_stage dut (
    .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i), .flush_i(flush_i),
    .alu_result_i(alu_result_i), .data_rb_i(data_rb_i), .write_reg_i(write_reg_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .reg_write_i(reg_write_i),
    .mem_to_reg_i(mem_to_reg_i), .mem_width_i(mem_width_i), .mem_unsigned_i(mem_unsigned_i),
    .halt_i(halt_i), .debug_addr_i(debug_addr_i),
    .exmem_alu_o(exmem_alu_o), .exmem_reg_o(exmem_reg_o), .exmem_reg_write_o(exmem_reg_write_o),
    .wb_data_o(wb_data_o), .wb_reg_o(wb_reg_o), .wb_reg_write_o(wb_reg_write_o),
    .misaligned_o(misaligned_o), .halt_o(halt_o), .debug_data_o(debug_data_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rg;
    logic        rw, mis, halt, chk;
  } wb_exp_t;

  typedef struct {
    logic [31:0] alu;
    logic [4:0]  rg;
    logic        rw, chk;
  } ex_exp_t;

  wb_exp_t    sbq[$];
  ex_exp_t    exq[$];
  logic [7:0] mem_m [1024];
  int         checks = 0;
  int         errors = 0;
  logic       issue = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input int w);
    return {mem_m[4*w+3], mem_m[4*w+2], mem_m[4*w+1], mem_m[4*w]};
  endfunction

  // Reference: instructions act on a flat byte array in program order.
  task automatic model(input logic [31:0] alu, rb, input logic [4:0] rg,
                       input logic rd, wr, rw, m2r, input logic [1:0] w,
                       input logic uns, hlt, output wb_exp_t e);
    int a, n;
    logic mis;
    logic [31:0] ld;
    a   = int'(alu[9:0]);
    n   = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    mis = (rd || wr) && (a % n != 0);
    ld  = 0;
    if (!mis) begin
      for (int i = 0; i < n; i++) ld = ld | (32'(mem_m[(a + i) % 1024]) << (8 * i));
      if (!uns && n < 4 && ld[8*n-1]) ld = ld | (32'hFFFF_FFFF << (8 * n));
    end
    if (wr && !mis) for (int i = 0; i < n; i++) mem_m[(a + i) % 1024] = rb[8*i +: 8];
    e = '{data: m2r ? ld : alu, rg: rg, rw: rw, mis: mis, halt: hlt, chk: 1'b1};
  endtask

  task automatic issue_op(input logic [31:0] alu, rb, input logic [4:0] rg,
                          input logic rd, wr, rw, m2r, input logic [1:0] w,
                          input logic uns, hlt, fl, input int stalls, input bit track);
    wb_exp_t e;
    alu_result_i = alu; data_rb_i = rb; write_reg_i = rg;
    mem_read_i = rd; mem_write_i = wr; reg_write_i = rw; mem_to_reg_i = m2r;
    mem_width_i = w; mem_unsigned_i = uns; halt_i = hlt; flush_i = fl;
    if (track) begin
      if (fl) begin
        e = '{data: 32'h0, rg: 5'd0, rw: 1'b0, mis: 1'b0, halt: 1'b0, chk: 1'b0};
        exq.push_back('{alu: alu, rg: rg, rw: 1'b0, chk: 1'b0});
      end else begin
        model(alu, rb, rg, rd, wr, rw, m2r, w, uns, hlt, e);
        exq.push_back('{alu: alu, rg: rg, rw: rw, chk: 1'b1});
      end
      sbq.push_back(e);
    end
    issue = track;
    for (int i = 0; i < stalls; i++) begin
      enable_i = 1'b0;
      @(negedge clk_i);
    end
    enable_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      issue_op(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    end
  endtask

  task automatic dbg_check(input string name, input logic [7:0] w);
    idle(2);
    debug_addr_i = w;
    @(negedge clk_i);
    chk(name, debug_data_o, model_word(int'(w)));
  endtask

  // Monitor: MEM/WB presents the instruction issued two enabled edges earlier.
  initial begin : monitor
    logic en, rst, iss, v1, v2, lw_valid, le_valid;
    wb_exp_t lw;
    ex_exp_t le;
    v1 = 0; v2 = 0; lw_valid = 0; le_valid = 0;
    forever begin
      @(posedge clk_i);
      en = enable_i; rst = reset_i; iss = issue;
      #1;
      if (rst) begin
        v1 = 0; v2 = 0; lw_valid = 0; le_valid = 0;
        sbq.delete(); exq.delete();
        chk("reset_outputs", {exmem_alu_o | wb_data_o | debug_data_o},  32'h0);
        chk("reset_flags", {22'h0, exmem_reg_o, exmem_reg_write_o, wb_reg_write_o,
                            misaligned_o, halt_o}, 32'h0);
        chk("reset_wb_reg", {27'h0, wb_reg_o}, 32'h0);
      end else if (en) begin
        v2 = v1; v1 = iss;
        lw_valid = 0; le_valid = 0;
        if (v2) begin
          if (sbq.size() == 0) chk("wb_queue_empty", 32'h1, 32'h0);
          else begin
            lw = sbq.pop_front();
            lw_valid = 1;
          end
        end
        if (v1) begin
          if (exq.size() == 0) chk("ex_queue_empty", 32'h1, 32'h0);
          else begin
            le = exq.pop_front();
            le_valid = 1;
          end
        end
      end
      if (!rst && lw_valid) begin
        if (lw.chk) chk(en ? "wb_data" : "wb_data_hold", wb_data_o, lw.data);
        chk(en ? "wb_ctrl" : "wb_ctrl_hold",
            {24'h0, lw.chk ? wb_reg_o : 5'd0, wb_reg_write_o, misaligned_o, halt_o},
            {24'h0, lw.chk ? lw.rg : 5'd0, lw.rw, lw.mis, lw.halt});
      end
      if (!rst && le_valid) begin
        if (le.chk) chk(en ? "exmem_fwd" : "exmem_fwd_hold", exmem_alu_o, le.alu);
        chk(en ? "exmem_ctrl" : "exmem_ctrl_hold",
            {26'h0, le.chk ? exmem_reg_o : 5'd0, exmem_reg_write_o},
            {26'h0, le.chk ? le.rg : 5'd0, le.rw});
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic [31:0] a, d;
    int          k;
    reset_i = 1'b1; enable_i = 1'b1; flush_i = 1'b0; debug_addr_i = 8'h0;
    alu_result_i = 0; data_rb_i = 0; write_reg_i = 0; mem_read_i = 0; mem_write_i = 0;
    reg_write_i = 0; mem_to_reg_i = 0; mem_width_i = 0; mem_unsigned_i = 0; halt_i = 0;
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;

    // Give every RAM word a known value.
    for (int w = 0; w < 256; w++) begin
      issue_op(32'(w * 4), $urandom(), 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0,
               0, 1'b1);
    end

    // SW then LW; SB then LB/LBU; misaligned SH/LH.
    issue_op(32'h10, 32'hDEADBEEF, 5'd1, 0, 1, 0, 0, 2'd2, 0, 0, 0, 0, 1);
    issue_op(32'h10, 32'h0, 5'd2, 1, 0, 1, 1, 2'd2, 0, 0, 0, 0, 1);
    issue_op(32'h12, 32'h80, 5'd3, 0, 1, 0, 0, 2'd0, 0, 0, 0, 0, 1);
    issue_op(32'h12, 32'h0, 5'd4, 1, 0, 1, 1, 2'd0, 0, 0, 0, 0, 1);
    issue_op(32'h12, 32'h0, 5'd5, 1, 0, 1, 1, 2'd0, 1, 0, 0, 0, 1);
    issue_op(32'h10, 32'h0, 5'd6, 1, 0, 1, 1, 2'd2, 0, 0, 0, 0, 1);
    issue_op(32'h13, 32'h1234, 5'd7, 0, 1, 1, 0, 2'd1, 0, 0, 0, 0, 1);
    issue_op(32'h13, 32'h0, 5'd8, 1, 0, 1, 1, 2'd1, 0, 0, 0, 0, 1);
    dbg_check("dbg_after_sb", 8'd4);
    chk("sb_word_value", model_word(4), 32'hDE80BEEF);

    // Stalled SW, then flushed SW, then plain ALU op.
    issue_op(32'h20, 32'hCAFEF00D, 5'd9, 0, 1, 0, 0, 2'd2, 0, 0, 0, 3, 1);
    issue_op(32'h20, 32'h0, 5'd10, 1, 0, 1, 1, 2'd2, 0, 0, 0, 3, 1);
    issue_op(32'h24, 32'h11111111, 5'd11, 0, 1, 1, 0, 2'd2, 0, 1, 1, 0, 1);
    issue_op(32'h24, 32'h0, 5'd12, 1, 0, 1, 1, 2'd2, 0, 0, 0, 0, 1);
    issue_op(32'h55, 32'h0, 5'd7, 0, 0, 1, 0, 2'd2, 0, 0, 0, 0, 1);
    dbg_check("dbg_after_stall", 8'd8);
    dbg_check("dbg_after_flush", 8'd9);

    // Debug port holds while disabled.
    debug_addr_i = 8'd8;
    @(negedge clk_i);
    enable_i = 1'b0;
    debug_addr_i = 8'd9;
    @(negedge clk_i);
    chk("dbg_hold", debug_data_o, model_word(8));
    enable_i = 1'b1;

    // Reset while an SW sits in EX/MEM: the store must not land.
    issue_op(32'h10, 32'h11111111, 5'd13, 0, 1, 0, 0, 2'd2, 0, 0, 0, 0, 0);
    reset_i = 1'b1;
    alu_result_i = 0; mem_write_i = 0;
    @(negedge clk_i);
    reset_i = 1'b0;
    debug_addr_i = 8'd4;
    @(negedge clk_i);
    chk("dbg_after_reset", debug_data_o, model_word(4));

    // Random traffic with stalls, flushes and wrapping high address bits.
    for (int n = 0; n < 3000; n++) begin
      a = $urandom();
      a[9:0] = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 31)) : 10'($urandom());
      d = $urandom();
      k = $urandom_range(0, 3);
      case (k)
        0: issue_op(a, d, 5'($urandom()), 0, 0, 1'($urandom()), 0, 2'($urandom()),
                    1'($urandom()), 1'($urandom()), 0, ($urandom_range(0, 7) == 0) ? 1 : 0, 1);
        1: issue_op(a, d, 5'($urandom()), 1, 0, 1'($urandom()), 1, 2'($urandom()),
                    1'($urandom()), 1'($urandom()), 0, ($urandom_range(0, 7) == 0) ? 2 : 0, 1);
        2: issue_op(a, d, 5'($urandom()), 0, 1, 1'($urandom()), 0, 2'($urandom()),
                    1'($urandom()), 1'($urandom()), 0, ($urandom_range(0, 7) == 0) ? 1 : 0, 1);
        default: issue_op(a, d, 5'($urandom()), 1'($urandom()), 1'($urandom()), 1, 1,
                          2'($urandom()), 0, 1, 1, 0, 1);
      endcase
    end
    idle(3);
    for (int w = 0; w < 8; w++) dbg_check("dbg_final", 8'(w));
    chk("queues_drained", 32'(sbq.size() + exq.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
